// File: rtl/seq_shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// One 4-bit ripple-carry adder is reused once per iteration: it adds the multiplicand into
// the high partial product, and the sum plus carry is shifted right into {acc, Q}.

// 4-bit ripple-carry adder with carry-in tied low.
module FourBitRippleCarryAdder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] S,
    output logic       c4
);

    // Ripple the carry through four full-adder stages.
    always_comb begin
        logic carry;
        S     = 4'b0000;
        carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        c4 = carry;
    end

endmodule

module seq_shift_add_multiplier (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] P
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] m_q, m_d;
    logic [3:0] q_q, q_d;
    logic [3:0] acc_q, acc_d;
    logic [1:0] count_q, count_d;
    logic [7:0] p_q, p_d;

    logic [3:0] sum;
    logic       c4;

    FourBitRippleCarryAdder u_adder (
        .A  (acc_q),
        .B  (m_q),
        .S  (sum),
        .c4 (c4)
    );

    // Next-state and datapath update; registers hold unless the state says otherwise.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        count_d = count_q;
        p_d     = p_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = 4'h0;
                    count_d = 2'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Add only when the current multiplier bit is set, then shift right by one.
                if (q_q[0]) begin
                    {acc_d, q_d} = {c4, sum, q_q[3:1]};
                end else begin
                    {acc_d, q_d} = {1'b0, acc_q, q_q[3:1]};
                end
                count_d = count_q + 2'd1;
                if (count_q == 2'd3) begin
                    p_d     = {acc_d, q_d};
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset that discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            m_q     <= 4'h0;
            q_q     <= 4'h0;
            acc_q   <= 4'h0;
            count_q <= 2'd0;
            p_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            p_q     <= p_d;
        end
    end

    // Moore outputs decoded from state only.
    always_comb begin
        ready = (state_q == StIdle);
        busy  = (state_q == StRun);
        done  = (state_q == StDone);
        P     = p_q;
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: table vectors, hand-written handshake and
// reset sequences, an exhaustive sweep and random operands checked against plain a*b.
module tb_seq_shift_add_multiplier;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] P;

    int vectors     = 0;
    int miscompares = 0;
    int done_total  = 0;
    int excl_viol   = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t tbl[6];

    seq_shift_add_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Track done pulses and any overlap of done with busy or ready.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_total++;
            if (busy || ready) excl_viol++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One handshake multiply with operands scrambled while the block is working.
    task automatic do_mult(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        int    guard     = 0;
        int    busy_cyc  = 0;
        int    lat       = -1;
        bit    seen      = 0;
        string tag;
        tag = $sformatf("%0d*%0d", a, b);
        while (!ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " ready_before"}, int'(ready), 1);
        A     = a;
        B     = b;
        start = 1'b1;
        // k counts negedges after the accept edge; the done cycle is the 5th clock counting
        // the accept cycle, i.e. k == 4.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            A     = 4'($urandom);
            B     = 4'($urandom);
            if (k == 0) check({tag, " ready_drop"}, int'(ready), 0);
            if (busy) busy_cyc++;
            if (seen && k == lat + 1) check({tag, " ready_after_done"}, int'(ready), 1);
            if (done && !seen) begin
                seen = 1;
                lat  = k;
                check({tag, " P"}, int'(P), int'(exp));
            end
        end
        check({tag, " done_seen"}, int'(seen), 1);
        check({tag, " latency"}, lat, 4);
        check({tag, " busy_cycles"}, busy_cyc, 4);
    endtask

    initial begin
        int d0;
        int first_done;
        int second_done;
        int ndone;
        logic [3:0] ra, rb;

        tbl[0] = '{a: 4'hF, b: 4'hF, p: 8'hE1};
        tbl[1] = '{a: 4'd13, b: 4'd11, p: 8'h8F};
        tbl[2] = '{a: 4'd7, b: 4'd0, p: 8'h00};
        tbl[3] = '{a: 4'd0, b: 4'd9, p: 8'h00};
        tbl[4] = '{a: 4'd9, b: 4'd9, p: 8'h51};
        tbl[5] = '{a: 4'd15, b: 4'd1, p: 8'h0F};

        // Reset state.
        rst_n = 1'b0;
        start = 1'b0;
        A     = 4'h0;
        B     = 4'h0;
        repeat (3) @(negedge clk);
        check("reset ready", int'(ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset P", int'(P), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 6; i++) do_mult(tbl[i].a, tbl[i].b, tbl[i].p);

        // start held high: products every 6 cycles; A=2,B=3 shown mid-RUN must be ignored.
        while (!ready) @(negedge clk);
        A = 4'd15;
        B = 4'd1;
        start = 1'b1;
        first_done = -1;
        second_done = -1;
        ndone = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 2) begin
                A = 4'd2;
                B = 4'd3;
            end
            if (i == 4) begin
                A = 4'd15;
                B = 4'd1;
            end
            if (done) begin
                ndone++;
                check($sformatf("b2b P #%0d", ndone), int'(P), 8'h0F);
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
            if (i == 2) check("b2b busy while start held", int'(busy), 1);
            if (ndone == 2) start = 1'b0;
        end
        check("b2b done count", ndone, 2);
        check("b2b first done cycle", first_done, 5);
        check("b2b period", second_done - first_done, 6);

        // Reset during the second RUN cycle of 9*9.
        while (!ready) @(negedge clk);
        A = 4'd9;
        B = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midreset busy before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset ready", int'(ready), 1);
        check("midreset busy", int'(busy), 0);
        check("midreset P", int'(P), 0);
        d0 = done_total;
        repeat (8) @(negedge clk);
        check("midreset no done", done_total - d0, 0);
        do_mult(4'd9, 4'd9, 8'h51);

        // Exhaustive sweep against plain multiplication.
        d0 = done_total;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_mult(4'(a), 4'(b), 8'(a * b));
            end
        end
        check("sweep done count", done_total - d0, 256);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            do_mult(ra, rb, 8'(int'(ra) * int'(rb)));
        end

        check("done exclusive of busy/ready", excl_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
